ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 keyboard receiver: samples PS2C/PS2D in the clk25 domain, checks frames, tracks
//  E0/F0 prefixes and shift state, maps set-2 scan codes to ASCII, and queues key events
//  in a FIFO with a valid/ready handshake. Feeds the CPU keyboard I/O port.
//  Replaces the release-only decoder with make/break/extended events, error reporting and buffering.
// PARAMETERS
//  FILTER_LEN   8      glitch-filter length in clk25 cycles; range 2..16
//  FIFO_DEPTH   8      event queue entries; power of 2, at least 2
//  TIMEOUT_CYC  25000  idle clk25 cycles allowed between bits mid-frame (1 ms)
//  EMIT_MODE    0      0 = all events, 1 = make only, 2 = break only (legacy behaviour)
// PORTS
//  clk25      in   1   system clock, 25 MHz
//  clr_n      in   1   asynchronous active-low reset
//  ps2c       in   1   PS/2 clock, asynchronous to clk25
//  ps2d       in   1   PS/2 data, asynchronous to clk25
//  ev_valid   out  1   FIFO head is valid
//  ev_ready   in   1   consumer accepts the head entry
//  ev_scan    out  8   scan code of the head entry
//  ev_ascii   out  8   ASCII of the head entry; 0 if unmapped
//  ev_break   out  1   head entry is a release
//  ev_ext     out  1   head entry was E0-prefixed
//  shift_held out  1   left or right shift currently down
//  frame_err  out  1   1-cycle pulse on a bad frame or timeout
//  overflow   out  1   sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (clr_n=0, async):
//   - every output 0; FIFO empty; FSM in IDLE
//   - filter registers all ones; filtered lines = 1
//   - prefix flags and shift flags cleared; a partial frame is discarded
//  Filter:
//   - filtered level changes only when all FILTER_LEN samples agree
//   - a bit event is a 1->0 transition of filtered ps2c, detected synchronously
//   - no logic is clocked by ps2c
//  Frame FSM: IDLE -> SHIFT -> CHECK -> IDLE
//   - IDLE: a bit event with d=0 (start bit) enters SHIFT with bitcnt=1; d=1 is ignored
//   - SHIFT: each bit event samples d: 8 data bits LSB first, then odd parity, then stop;
//     after the stop bit (bitcnt=10) go to CHECK
//   - CHECK, 1 cycle: if parity is odd and stop=1, the byte is valid; else pulse frame_err, drop
//   - SHIFT watchdog: counter reset on each bit event; at TIMEOUT_CYC -> pulse frame_err, go IDLE
//  Decoder (byte valid):
//   - E0 sets ext_pend; F0 sets brk_pend; neither produces an event
//   - any other byte forms event {ext_pend, brk_pend, byte}, then clears both pends
//   - shift tracking: non-ext 0x12 / 0x59 make sets that side, break clears it;
//     shift keys still produce events
//  ASCII map (non-ext only; ext and unmapped codes -> 0):
//   - letters: set-2 table a..z = 0x61..0x7A; 0x41..0x5A when shift_held at decode time
//   - digits: 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'; shift does not change them
//   - space 29->20; enter 5A->0A; backspace 66->08
//  Event filter: EMIT_MODE 1 discards breaks; mode 2 discards makes; discarded events are not pushed
//  FIFO, 18-bit entries {ext, brk, scan, ascii}:
//   - ev_* outputs show the head; ev_valid = !empty; pop when ev_valid & ev_ready
//   - ev_* outputs are stable while ev_valid=1 and ev_ready=0
//   - push when full without a pop in the same cycle: drop the new event, set overflow
//   - push and pop in the same cycle when full: both happen, count unchanged
//   - push when empty: ev_valid rises 3 clk25 cycles after the CHECK cycle
//   - pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits
// TESTING
//  1. EMIT=0, frames 1C, F0, 1C -> events {scan 1C, brk 0, ascii 61}, then {1C, 1, 61}, in order
//  2. 12 make, 1C make -> ascii 41, shift_held=1; F0 12, 1C -> shift_held=0, ascii 61
//  3. E0 75 -> one event, ext=1, scan 75, ascii 00; a following 1C event has ext=0
//  4. 1C sent with even parity -> frame_err for 1 cycle, no event; 5 bits then 25000 idle cycles
//     -> frame_err; the next good frame decodes correctly
//  5. ev_ready=0, FIFO_DEPTH+1 make codes -> FIFO_DEPTH entries held, overflow=1;
//     draining returns the first FIFO_DEPTH codes in order
//  6. 3-cycle low glitch on ps2c -> no bit counted; clr_n low mid-frame -> all outputs 0,
//     next frame decodes; EMIT=2 with 1C, F0 1C -> only the break event

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 set-2 keyboard receiver: filtered line sampling, frame checking,
// prefix/shift tracking, ASCII mapping and a buffered event queue.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 25000,
   parameter int EMIT_MODE   = 0
) (
   input  logic       clk25,
   input  logic       clr_n,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_scan,
   output logic [7:0] ev_ascii,
   output logic       ev_break,
   output logic       ev_ext,
   output logic       shift_held,
   output logic       frame_err,
   output logic       overflow
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   logic                  c_s1, c_s2, d_s1, d_s2;
   logic [FILTER_LEN-1:0] c_sh, d_sh;
   logic                  fc, fd, fc_q;
   logic                  bit_ev;

   always_ff @(posedge clk25 or negedge clr_n) begin
      if (!clr_n) begin
         c_s1 <= 1'b1;
         c_s2 <= 1'b1;
         d_s1 <= 1'b1;
         d_s2 <= 1'b1;
         c_sh <= '1;
         d_sh <= '1;
         fc   <= 1'b1;
         fd   <= 1'b1;
         fc_q <= 1'b1;
      end else begin
         c_s1 <= ps2c;
         c_s2 <= c_s1;
         d_s1 <= ps2d;
         d_s2 <= d_s1;
         c_sh <= {c_sh[FILTER_LEN-2:0], c_s2};
         d_sh <= {d_sh[FILTER_LEN-2:0], d_s2};
         if (&c_sh) fc <= 1'b1;
         else if (~|c_sh) fc <= 1'b0;
         if (&d_sh) fd <= 1'b1;
         else if (~|d_sh) fd <= 1'b0;
         fc_q <= fc;
      end
   end

   assign bit_ev = fc_q & ~fc;

   state_t          state, state_n;
   logic [3:0]      bitcnt, bitcnt_n;
   logic [9:0]      sr, sr_n;
   logic [WD_W-1:0] wdog, wdog_n;
   logic            err_n, byte_ok;
   logic            byte_vld;
   logic [7:0]      byte_q;

   always_ff @(posedge clk25 or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         bitcnt    <= '0;
         sr        <= '0;
         wdog      <= '0;
         frame_err <= 1'b0;
         byte_vld  <= 1'b0;
         byte_q    <= '0;
      end else begin
         state     <= state_n;
         bitcnt    <= bitcnt_n;
         sr        <= sr_n;
         wdog      <= wdog_n;
         frame_err <= err_n;
         byte_vld  <= byte_ok;
         if (byte_ok) byte_q <= sr[7:0];
      end
   end

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      sr_n     = sr;
      wdog_n   = wdog;
      err_n    = 1'b0;
      byte_ok  = 1'b0;
      case (state)
         IDLE: begin
            wdog_n = '0;
            if (bit_ev && !fd) begin
               state_n  = SHIFT;
               bitcnt_n = 4'd1;
            end
         end
         SHIFT: begin
            if (bit_ev) begin
               sr_n     = {fd, sr[9:1]};
               wdog_n   = '0;
               bitcnt_n = bitcnt + 4'd1;
               if (bitcnt == 4'd10) state_n = CHECK;
            end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               wdog_n = wdog + 1'b1;
            end
         end
         CHECK: begin
            // sr[8:0] = data + parity, sr[9] = stop
            if ((^sr[8:0]) && sr[9]) byte_ok = 1'b1;
            else err_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   function automatic logic [7:0] to_ascii(input logic [7:0] c,
                                           input logic up);
      logic [7:0] a;
      a = 8'h00;
      case (c)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63;
         8'h23: a = 8'h64; 8'h24: a = 8'h65; 8'h2B: a = 8'h66;
         8'h34: a = 8'h67; 8'h33: a = 8'h68; 8'h43: a = 8'h69;
         8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F;
         8'h4D: a = 8'h70; 8'h15: a = 8'h71; 8'h2D: a = 8'h72;
         8'h1B: a = 8'h73; 8'h2C: a = 8'h74; 8'h3C: a = 8'h75;
         8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32;
         8'h26: a = 8'h33; 8'h25: a = 8'h34; 8'h2E: a = 8'h35;
         8'h36: a = 8'h36; 8'h3D: a = 8'h37; 8'h3E: a = 8'h38;
         8'h46: a = 8'h39;
         8'h29: a = 8'h20; 8'h5A: a = 8'h0A; 8'h66: a = 8'h08;
         default: a = 8'h00;
      endcase
      if (up && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
      return a;
   endfunction

   logic        ext_pend, brk_pend, lsh, rsh, keep;
   logic        evt_vld;
   logic [17:0] evt_data;

   assign shift_held = lsh | rsh;

   always_comb begin
      keep = 1'b1;
      if (EMIT_MODE == 1) keep = !brk_pend;
      else if (EMIT_MODE == 2) keep = brk_pend;
   end

   always_ff @(posedge clk25 or negedge clr_n) begin
      if (!clr_n) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
         lsh      <= 1'b0;
         rsh      <= 1'b0;
         evt_vld  <= 1'b0;
         evt_data <= '0;
      end else begin
         evt_vld <= 1'b0;
         if (byte_vld) begin
            if (byte_q == 8'hE0) begin
               ext_pend <= 1'b1;
            end else if (byte_q == 8'hF0) begin
               brk_pend <= 1'b1;
            end else begin
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
               evt_vld  <= keep;
               evt_data <= {ext_pend, brk_pend, byte_q,
                            ext_pend ? 8'h00 :
                            to_ascii(byte_q, shift_held)};
               if (!ext_pend && byte_q == 8'h12) lsh <= !brk_pend;
               if (!ext_pend && byte_q == 8'h59) rsh <= !brk_pend;
            end
         end
      end
   end

   logic [17:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          full, pop, do_push;

   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign ev_valid = (count != '0);
   assign pop      = ev_valid & ev_ready;
   assign do_push  = evt_vld & (!full | pop);

   always_ff @(posedge clk25) begin
      if (do_push) mem[wptr] <= evt_data;
   end

   always_ff @(posedge clk25 or negedge clr_n) begin
      if (!clr_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (do_push && !pop) count <= count + 1'b1;
         else if (!do_push && pop) count <= count - 1'b1;
         if (evt_vld && !do_push) overflow <= 1'b1;
      end
   end

   assign {ev_ext, ev_break, ev_scan, ev_ascii} =
      ev_valid ? mem[rptr] : 18'h0;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: one all-events instance and one
// break-only instance share the PS/2 lines and reset.
module tb_ps2_keyboard_rx;

   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic       rdy = 1'b0;
   logic       rdy2 = 1'b0;

   logic       v0, b0, x0, sh0, fe0, ov0;
   logic [7:0] s0, a0;
   logic       v2, b2, x2, sh2, fe2, ov2;
   logic [7:0] s2, a2;

   int checks = 0;
   int errors = 0;
   int errcnt = 0;

   always #5 clk = ~clk;

   ps2_keyboard_rx #(.EMIT_MODE(0)) dut0 (
      .clk25(clk), .clr_n(clr_n), .ps2c(ps2c), .ps2d(ps2d),
      .ev_valid(v0), .ev_ready(rdy), .ev_scan(s0), .ev_ascii(a0),
      .ev_break(b0), .ev_ext(x0), .shift_held(sh0),
      .frame_err(fe0), .overflow(ov0)
   );

   ps2_keyboard_rx #(.EMIT_MODE(2)) dut2 (
      .clk25(clk), .clr_n(clr_n), .ps2c(ps2c), .ps2d(ps2d),
      .ev_valid(v2), .ev_ready(rdy2), .ev_scan(s2), .ev_ascii(a2),
      .ev_break(b2), .ev_ext(x2), .shift_held(sh2),
      .frame_err(fe2), .overflow(ov2)
   );

   always @(negedge clk) if (fe0) errcnt++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2d = bits[i];
         cyc(HALF);
         ps2c = 1'b0;
         cyc(HALF);
         ps2c = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic bad);
      logic par;
      par = ~(^b) ^ bad;
      send_bits({1'b1, par, b, 1'b0}, 11);
      cyc(HALF);
      ps2d = 1'b1;
      cyc(40);
   endtask

   task automatic take(input string tag, input logic [7:0] scan,
                       input logic brk, input logic ext,
                       input logic [7:0] asc);
      int n;
      n = 0;
      @(negedge clk);
      while (!v0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'b0, v0}, 32'd1);
      chk({tag, "_ev"}, {14'b0, x0, b0, s0, a0},
          {14'b0, ext, brk, scan, asc});
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
   endtask

   initial begin
      int e0;
      cyc(3);
      @(negedge clk);
      chk("reset_outs", {12'b0, v0, s0, a0, b0, x0, sh0, fe0, ov0}, 0);
      clr_n = 1'b1;
      cyc(20);

      send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
      take("t1_make", 8'h1C, 0, 0, 8'h61);
      take("t1_brk", 8'h1C, 1, 0, 8'h61);
      cyc(5);
      chk("t1_empty", {31'b0, v0}, 0);

      send(8'h12, 0); send(8'h1C, 0);
      chk("t2_shift_on", {31'b0, sh0}, 1);
      take("t2_lshift", 8'h12, 0, 0, 8'h00);
      take("t2_upper", 8'h1C, 0, 0, 8'h41);
      send(8'hF0, 0); send(8'h12, 0); send(8'h1C, 0);
      chk("t2_shift_off", {31'b0, sh0}, 0);
      take("t2_lshift_brk", 8'h12, 1, 0, 8'h00);
      take("t2_lower", 8'h1C, 0, 0, 8'h61);

      send(8'hE0, 0); send(8'h75, 0); send(8'h1C, 0);
      take("t3_ext", 8'h75, 0, 1, 8'h00);
      take("t3_noext", 8'h1C, 0, 0, 8'h61);

      e0 = errcnt;
      send(8'h1C, 1);
      cyc(50);
      chk("t4_parity_err", errcnt - e0, 1);
      chk("t4_no_event", {31'b0, v0}, 0);
      send_bits(11'h7F0, 5);
      cyc(24000);
      chk("t4_no_early_to", errcnt - e0, 1);
      cyc(1500);
      chk("t4_timeout_err", errcnt - e0, 2);
      send(8'h29, 0);
      take("t4_recover", 8'h29, 0, 0, 8'h20);

      chk("t5_ovf_clear", {31'b0, ov0}, 0);
      send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0);
      send(8'h23, 0); send(8'h24, 0); send(8'h2B, 0);
      send(8'h34, 0); send(8'h33, 0); send(8'h43, 0);
      chk("t5_overflow", {31'b0, ov0}, 1);
      take("t5_d0", 8'h1C, 0, 0, 8'h61);
      take("t5_d1", 8'h32, 0, 0, 8'h62);
      take("t5_d2", 8'h21, 0, 0, 8'h63);
      take("t5_d3", 8'h23, 0, 0, 8'h64);
      take("t5_d4", 8'h24, 0, 0, 8'h65);
      take("t5_d5", 8'h2B, 0, 0, 8'h66);
      take("t5_d6", 8'h34, 0, 0, 8'h67);
      take("t5_d7", 8'h33, 0, 0, 8'h68);
      cyc(5);
      chk("t5_drained", {31'b0, v0}, 0);

      e0 = errcnt;
      ps2d = 1'b0;
      cyc(30);
      ps2c = 1'b0;
      cyc(3);
      ps2c = 1'b1;
      cyc(30);
      ps2d = 1'b1;
      cyc(30);
      send(8'h1C, 0);
      take("t6_glitch", 8'h1C, 0, 0, 8'h61);
      chk("t6_glitch_noerr", errcnt - e0, 0);

      send(8'h12, 0);
      chk("t6_pre_rst_sh", {30'b0, sh0, v0}, 3);
      send_bits(11'h7F0, 4);
      clr_n = 1'b0;
      cyc(5);
      @(negedge clk);
      chk("t6_rst_outs", {12'b0, v0, s0, a0, b0, x0, sh0, fe0, ov0}, 0);
      chk("t6_rst_outs2", {12'b0, v2, s2, a2, b2, x2, sh2, fe2, ov2}, 0);
      ps2c = 1'b1;
      ps2d = 1'b1;
      clr_n = 1'b1;
      cyc(50);
      send(8'h1C, 0);
      take("t6_post_rst", 8'h1C, 0, 0, 8'h61);
      cyc(10);
      chk("t6_m2_no_make", {31'b0, v2}, 0);
      send(8'hF0, 0); send(8'h1C, 0);
      cyc(10);
      @(negedge clk);
      chk("t6_m2_ev", {13'b0, v2, x2, b2, s2, a2},
          {13'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'h61});
      rdy2 = 1'b1;
      @(negedge clk);
      rdy2 = 1'b0;
      cyc(5);
      @(negedge clk);
      chk("t6_m2_empty", {31'b0, v2}, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
